nib_seq_add32: RTL and testbench
================================

NIB_SEQ_ADD32 -- requirements
Module: nib_seq_add32

Interface
REQ-001 Parameters: none; all constants SHALL come from the shared package (REQ-030).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operand set a/b/cin is valid.
REQ-005 in_ready  output  1  block accepts an operand set.
REQ-006 a  input  32  addend A, unsigned or two's complement.
REQ-007 b  input  32  addend B.
REQ-008 cin  input  1  carry-in to bit 0.
REQ-009 out_valid  output  1  sum/cout/ovf valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 sum  output  32  a + b + cin, modulo 2^32.
REQ-012 cout  output  1  carry out of bit 31.
REQ-013 ovf  output  1  signed overflow: carry into bit 31 XOR carry out of bit 31.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
REQ-015 IDLE: in_ready=1, out_valid=0; on in_valid=1, latch a, b and cin into operand/carry registers, clear nib_idx to 0, then go to RUN.
REQ-016 RUN: in_ready=0; each cycle, one 4-bit slice SHALL add nibble nib_idx of A and B with the carry register; the result SHALL be written to sum[4*nib_idx+3 : 4*nib_idx]; the slice carry-out SHALL go into the carry register; nib_idx SHALL increment.
REQ-017 On the RUN cycle with nib_idx=7: capture the slice carry-out into cout, capture slice carry-out XOR slice carry-into-bit-3 into ovf, then go to DONE.
REQ-018 Latency: exactly 8 RUN cycles; out_valid SHALL rise on the 9th rising edge after the in_valid/in_ready handshake edge.
REQ-019 DONE: out_valid=1; sum, cout and ovf SHALL be held stable until an out_valid and out_ready handshake; then go to IDLE.
REQ-020 out_ready=0 in DONE SHALL hold DONE and all outputs indefinitely; no result is ever dropped.
REQ-021 in_valid asserted in RUN or DONE SHALL be ignored, with no operand capture.
REQ-022 The result handshake and a new in_valid on the same cycle: go to IDLE first. A new operand set SHALL be accepted no earlier than the following cycle; throughput is 1 result per at least 10 cycles.
REQ-023 Carry wrap-around: cout SHALL reflect only bit 31; nothing carries over into the next operation (the carry register reloads from cin on accept).
REQ-024 sum SHALL be updated only in RUN; in IDLE it holds the last completed result.
REQ-025 The whole datapath is unsigned 32-bit; ovf is informational only and is valid only while out_valid=1.

Reset
REQ-026 rst_n=0 at a rising edge SHALL force IDLE, nib_idx=0, carry register=0, sum=0, cout=0, ovf=0, out_valid=0.
REQ-027 in_ready SHALL be 1 on the first cycle after reset release.
REQ-028 Reset in RUN or DONE SHALL abort the operation; no partial result may appear on out_valid.
REQ-029 Reset SHALL have priority over all handshakes on the same edge.

Structure
REQ-030 The shared package SHALL hold the state enum (IDLE/RUN/DONE), NIB_W=4, NIBBLES=8 and LAST_NIB=7.
REQ-031 One sub-module nib_slice4 SHALL exist: a combinational 4-bit ripple adder made of four full-adder cells.
REQ-032 nib_slice4 ports: two 4-bit addends, carry-in, 4-bit sum, carry-out, and carry-into-bit-3 (for ovf).
REQ-033 Exactly one nib_slice4 SHALL be instantiated; the FSM, the nibble mux and the result registers live in nib_seq_add32.

Verification
REQ-034 a=0xFFFFFFFF, b=0, cin=1 -> sum=0x00000000, cout=1, ovf=0, out_valid on the 9th edge after accept.
REQ-035 a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1; and a=0x80000000, b=0x80000000 -> sum=0, cout=1, ovf=1.
REQ-036 a=0x12345678, b=0x9ABCDEF0, cin=0, out_ready held 0 for 5 cycles in DONE -> sum=0xACF13568, cout=0 held stable, in_ready=0 throughout, a new in_valid ignored.
REQ-037 rst_n pulsed low at RUN nib_idx=4 -> next cycle IDLE, out_valid=0, sum=0; next operation 1+1 -> sum=0x00000002.
REQ-038 Back-to-back: 100 random operand sets with out_ready=1 -> every result equals reference a+b+cin; no lost or duplicated results; spacing of at least 10 cycles.

Source files
------------

// File: rtl/nib_seq_add32_pkg.sv
// rtl/nib_seq_add32_pkg.sv - shared constants and state type for the nibble-serial 32-bit adder
//
// Purpose: holds the FSM state encoding and nibble geometry used by
//          nib_seq_add32 and nib_slice4.
// Contents: state_e (IDLE/RUN/DONE), NIB_W, NIBBLES, NIB_IDX_W, LAST_NIB.

package nib_seq_add32_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NIB_W     = 4;
    localparam int NIBBLES   = 8;
    localparam int NIB_IDX_W = $clog2(NIBBLES);
    localparam logic [NIB_IDX_W-1:0] LAST_NIB = NIB_IDX_W'(NIBBLES - 1);

endpackage

// File: rtl/nib_seq_add32_nib_slice4.sv
// rtl/nib_seq_add32_nib_slice4.sv - combinational 4-bit ripple adder built from full-adder cells
//
// Purpose: adds one nibble of each operand plus a carry-in.
// Ports:
//   i_a, i_b  4-bit addends
//   i_cin     carry into bit 0
//   o_sum     4-bit sum
//   o_cout    carry out of bit 3
//   o_c3      carry into bit 3 (used for signed overflow on the top nibble)

import nib_seq_add32_pkg::*;

module nib_slice4 (
    input  logic [NIB_W-1:0] i_a,
    input  logic [NIB_W-1:0] i_b,
    input  logic             i_cin,
    output logic [NIB_W-1:0] o_sum,
    output logic             o_cout,
    output logic             o_c3
);

    // w_carry[i] is the carry into bit i; w_carry[NIB_W] is the carry out.
    logic [NIB_W:0] w_carry;

    assign w_carry[0] = i_cin;

    for (genvar i = 0; i < NIB_W; i++) begin : g_fa
        assign o_sum[i]     = i_a[i] ^ i_b[i] ^ w_carry[i];
        assign w_carry[i+1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_cout = w_carry[NIB_W];
    assign o_c3   = w_carry[NIB_W-1];

endmodule

// File: rtl/nib_seq_add32.sv
// rtl/nib_seq_add32.sv - nibble-serial 32-bit adder with valid/ready handshakes
//
// Purpose: accepts a/b/cin, adds one nibble per cycle over 8 RUN cycles using a
//          single 4-bit slice, then presents sum/cout/ovf until consumed.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid, in_ready    operand handshake
//   a, b, cin             operands and carry-in
//   out_valid, out_ready  result handshake
//   sum, cout, ovf        result, carry out of bit 31, signed overflow

import nib_seq_add32_pkg::*;

module nib_seq_add32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] sum,
    output logic        cout,
    output logic        ovf
);

    state_e                 r_state;
    logic [31:0]            r_a;
    logic [31:0]            r_b;
    logic                   r_carry;
    logic [NIB_IDX_W-1:0]   r_nib_idx;
    logic [31:0]            r_sum;
    logic                   r_cout;
    logic                   r_ovf;
    logic                   r_out_valid;
    logic                   r_in_ready;

    logic [NIB_IDX_W+1:0]   w_bit_base;
    logic [NIB_W-1:0]       w_nib_a;
    logic [NIB_W-1:0]       w_nib_b;
    logic [NIB_W-1:0]       w_nib_sum;
    logic                   w_nib_cout;
    logic                   w_nib_c3;

    // Bit offset of the current nibble is nib_idx * 4.
    assign w_bit_base = {r_nib_idx, 2'b00};
    assign w_nib_a    = r_a[w_bit_base +: NIB_W];
    assign w_nib_b    = r_b[w_bit_base +: NIB_W];

    nib_slice4 u_slice (
        .i_a    (w_nib_a),
        .i_b    (w_nib_b),
        .i_cin  (r_carry),
        .o_sum  (w_nib_sum),
        .o_cout (w_nib_cout),
        .o_c3   (w_nib_c3)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_nib_idx   <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_carry    <= cin;
                        r_nib_idx  <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_sum[w_bit_base +: NIB_W] <= w_nib_sum;
                    r_carry                    <= w_nib_cout;
                    r_nib_idx                  <= r_nib_idx + 1'b1;
                    if (r_nib_idx == LAST_NIB) begin
                        r_cout      <= w_nib_cout;
                        // Carry into the sign bit differs from carry out of it.
                        r_ovf       <= w_nib_cout ^ w_nib_c3;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    // in_ready only returns next cycle, so a same-cycle
                    // in_valid is never taken here.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_nib_seq_add32.sv
// tb/tb_nib_seq_add32.sv - scoreboard testbench for nib_seq_add32

module tb_nib_seq_add32;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;

    int   n_checks;
    int   n_fail;
    int   cyc;
    int   n_results;
    res_t sb_q[$];

    nib_seq_add32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && out_valid && out_ready) n_results <= n_results + 1;
    end

    function automatic res_t ref_add(input logic [31:0] av, input logic [31:0] bv, input logic cv);
        logic [32:0] full;
        res_t r;
        full   = {1'b0, av} + {1'b0, bv} + {32'd0, cv};
        r.sum  = full[31:0];
        r.cout = full[32];
        r.ovf  = (av[31] == bv[31]) && (full[31] != av[31]);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for in_ready (bounded), drives one operand set through the
    // handshake edge and records the expected result. Returns #1 after that edge.
    task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                         output bit ok, output int acc_cyc);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        ok = in_ready;
        a = av;
        b = bv;
        cin = cv;
        in_valid = 1'b1;
        @(posedge clk);
        acc_cyc = cyc;
        #1;
        in_valid = 1'b0;
        if (ok) sb_q.push_back(ref_add(av, bv, cv));
    endtask

    // Counts edges after the accept edge until out_valid is seen (bounded).
    task automatic wait_out(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        while (!ok && lat < 40) begin
            tick();
            lat++;
            ok = out_valid;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        a = 32'hFFFF_FFFF;
        b = 32'h1;
        cin = 1'b1;
        out_ready = 1'b0;
        tick();
        tick();
        in_valid = 1'b0;
        n_checks += 5;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        if (sum !== 32'h0)      begin n_fail++; $display("FAIL reset_sum got %h want 00000000", sum); end
        if (cout !== 1'b0)      begin n_fail++; $display("FAIL reset_cout got %b want 0", cout); end
        if (ovf !== 1'b0)       begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf); end
        if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_corners();
        logic [31:0] av [3];
        logic [31:0] bv [3];
        logic        cv [3];
        av = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
        bv = '{32'h0000_0000, 32'h0000_0001, 32'h8000_0000};
        cv = '{1'b1, 1'b0, 1'b0};
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bit   ok;
            int   lat;
            int   acc;
            res_t exp_r;
            issue(av[i], bv[i], cv[i], ok, acc);
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL corner%0d_accept in_ready stayed 0", i); end
            wait_out(lat, ok);
            n_checks++;
            if (!ok || lat != 8) begin
                n_fail++; $display("FAIL corner%0d_latency got %0d edges after accept want 8 (9th edge counting accept)", i, lat);
            end
            exp_r = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
            n_checks += 3;
            if (sum !== exp_r.sum)   begin n_fail++; $display("FAIL corner%0d_sum got %h want %h", i, sum, exp_r.sum); end
            if (cout !== exp_r.cout) begin n_fail++; $display("FAIL corner%0d_cout got %b want %b", i, cout, exp_r.cout); end
            if (ovf !== exp_r.ovf)   begin n_fail++; $display("FAIL corner%0d_ovf got %b want %b", i, ovf, exp_r.ovf); end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            n_checks += 2;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL corner%0d_release got out_valid %b want 0", i, out_valid); end
            if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL corner%0d_idle got in_ready %b want 1", i, in_ready); end
        end
    endtask

    task automatic test_stall();
        bit   ok;
        int   lat;
        int   acc;
        res_t exp_r;
        out_ready = 1'b0;
        issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, ok, acc);
        // Operands presented during RUN must be ignored.
        in_valid = 1'b1;
        a = 32'hDEAD_BEEF;
        b = 32'h1111_1111;
        cin = 1'b1;
        wait_out(lat, ok);
        exp_r = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        n_checks += 2;
        if (!ok) begin n_fail++; $display("FAIL stall_out_valid timeout after %0d edges", lat); end
        if (exp_r.sum !== 32'hACF1_3568) begin n_fail++; $display("FAIL stall_ref got %h want acf13568", exp_r.sum); end
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks += 4;
            if (out_valid !== 1'b1)     begin n_fail++; $display("FAIL stall_hold_valid cyc%0d got %b want 1", k, out_valid); end
            if (sum !== 32'hACF1_3568)  begin n_fail++; $display("FAIL stall_hold_sum cyc%0d got %h want acf13568", k, sum); end
            if (cout !== 1'b0)          begin n_fail++; $display("FAIL stall_hold_cout cyc%0d got %b want 0", k, cout); end
            if (in_ready !== 1'b0)      begin n_fail++; $display("FAIL stall_in_ready cyc%0d got %b want 0", k, in_ready); end
        end
        // Release with in_valid still high: block must pass through IDLE first.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        n_checks += 3;
        if (out_valid !== 1'b0)    begin n_fail++; $display("FAIL stall_release got out_valid %b want 0", out_valid); end
        if (in_ready !== 1'b1)     begin n_fail++; $display("FAIL stall_idle got in_ready %b want 1", in_ready); end
        if (sum !== 32'hACF1_3568) begin n_fail++; $display("FAIL stall_idle_sum got %h want acf13568", sum); end
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || sum !== 32'hACF1_3568) begin
            n_fail++; $display("FAIL stall_no_capture got in_ready %b sum %h want 1 acf13568", in_ready, sum);
        end
    endtask

    task automatic test_abort();
        bit   ok;
        int   lat;
        int   acc;
        res_t exp_r;
        bit   seen;
        out_ready = 1'b1;
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, ok, acc);
        void'(sb_q.pop_back());
        for (int k = 0; k < 4; k++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks += 4;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_out_valid got %b want 0", out_valid); end
        if (sum !== 32'h0)      begin n_fail++; $display("FAIL abort_sum got %h want 00000000", sum); end
        if (cout !== 1'b0)      begin n_fail++; $display("FAIL abort_cout got %b want 0", cout); end
        if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL abort_in_ready got %b want 1", in_ready); end
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL abort_partial got out_valid 1 want 0"); end
        issue(32'h1, 32'h1, 1'b0, ok, acc);
        wait_out(lat, ok);
        exp_r = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        n_checks += 2;
        if (!ok || lat != 8) begin n_fail++; $display("FAIL abort_next_latency got %0d want 8", lat); end
        if (sum !== exp_r.sum || sum !== 32'h2) begin n_fail++; $display("FAIL abort_next_sum got %h want 00000002", sum); end
        tick();
    endtask

    task automatic test_back_to_back();
        int prev_acc;
        int start_results;
        int n_ops;
        out_ready = 1'b1;
        prev_acc = -1;
        n_ops = 100;
        start_results = n_results;
        for (int i = 0; i < n_ops; i++) begin
            bit          ok;
            int          lat;
            int          acc;
            res_t        exp_r;
            logic [31:0] av;
            logic [31:0] bv;
            logic        cv;
            av = $urandom();
            bv = $urandom();
            cv = 1'($urandom_range(1));
            if (i == 0) begin av = 32'hFFFF_FFFF; bv = 32'h0000_0001; cv = 1'b1; end
            issue(av, bv, cv, ok, acc);
            if (prev_acc >= 0) begin
                n_checks++;
                if (acc - prev_acc < 10) begin n_fail++; $display("FAIL b2b_spacing op%0d got %0d cycles want >=10", i, acc - prev_acc); end
            end
            prev_acc = acc;
            wait_out(lat, ok);
            exp_r = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
            n_checks++;
            if (!ok || {sum, cout, ovf} !== {exp_r.sum, exp_r.cout, exp_r.ovf}) begin
                n_fail++;
                $display("FAIL b2b_result op%0d a=%h b=%h cin=%b got %h/%b/%b want %h/%b/%b",
                         i, av, bv, cv, sum, cout, ovf, exp_r.sum, exp_r.cout, exp_r.ovf);
            end
            tick();
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_dup op%0d got out_valid %b want 0", i, out_valid); end
        end
        tick();
        n_checks += 2;
        if (n_results - start_results != n_ops) begin
            n_fail++; $display("FAIL b2b_count got %0d results want %0d", n_results - start_results, n_ops);
        end
        if (sb_q.size() != 0) begin n_fail++; $display("FAIL b2b_scoreboard got %0d left want 0", sb_q.size()); end
        out_ready = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        n_results = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        test_reset();
        test_corners();
        test_stall();
        test_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
